mastermind_scorer: RTL and testbench
====================================

Name: mastermind_scorer

Overview:
- Downstream of the Mastermind game FSM.
- Takes a submitted 4-slot colour guess and the secret answer, and computes exact matches (right colour, right slot) and partial matches (right colour, wrong slot), with duplicate-correct accounting.
- Reports the result with a done pulse and a win flag.
- Keeps a per-guess feedback history that the VGA renderer reads for drawing feedback pegs.
- Iterative (one compare per cycle), not combinational.

Parameters:
- NUM_SLOTS, 4, colour slots per guess.
- COLOR_W, 3, bits per slot colour code.
- MAX_GUESSES, 6, history depth (guess rows).

Ports:
- Clk  in  1  system clock (100 MHz)
- Reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to score guess/answer
- guess  in  12  guess; slot i = bits [3i+2:3i], slot 0 in LSBs
- answer  in  12  secret answer, same packing
- guess_num  in  3  history row to write (0..MAX_GUESSES-1)
- busy  out  1  scoring in progress
- done  out  1  one-cycle pulse, result valid
- exact_cnt  out  3  exact matches of last scored guess (0..4)
- partial_cnt  out  3  partial matches of last scored guess (0..4)
- win  out  1  high when last exact_cnt == 4; sticky until Reset
- rd_idx  in  3  history read index (VGA side)
- rd_exact  out  3  exact count stored at rd_idx
- rd_partial  out  3  partial count stored at rd_idx
- rd_valid  out  1  row rd_idx has been written since Reset

Behaviour:
- Reset (synchronous, active-high, Clk edge):
  - State goes to IDLE.
  - busy, done, win, exact_cnt and partial_cnt go to 0.
  - All history rows and their valid bits are cleared.
  - Reset overrides everything, including mid-scoring; an aborted score never writes history or pulses done.
- FSM states: IDLE, EXACT, PARTIAL, DONE.
- IDLE:
  - When start=1, capture guess, answer and guess_num into internal registers.
  - Clear the used_g/used_a masks and both counters, then go to EXACT.
  - start is ignored in every other state; no queueing.
- EXACT (NUM_SLOTS cycles, index i = 0..3):
  - If g[i] == a[i] and g[i] is non-blank: increment exact, set used_g[i] and used_a[i].
  - Blank = colour 0 or 7; blanks never match, either exact or partial.
- PARTIAL (NUM_SLOTS² cycles, i outer, j inner, both 0..3):
  - If !used_g[i], !used_a[j], g[i] == a[j] and g[i] is non-blank: increment partial, set used_g[i] and used_a[j].
  - Each answer slot is consumed at most once; exact + partial ≤ 4 always.
- DONE (1 cycle):
  - Load exact_cnt/partial_cnt from the working counters.
  - Pulse done=1.
  - Set win if exact == 4.
  - If captured guess_num < MAX_GUESSES, write the row and set its valid bit; otherwise skip the history write (the result is still reported).
  - Return to IDLE.
- Latency: start high in cycle 0 → EXACT cycles 1–4 → PARTIAL cycles 5–20 → done high in cycle 21. Outputs and history are visible from cycle 21.
- busy is high in cycles 1–21. A new start is accepted in cycle 22 at the earliest.
- exact_cnt/partial_cnt hold their values until the next DONE.
- History write to an already-valid row overwrites it.
- History read is combinational on rd_idx (registered array, mux read). rd_idx ≥ MAX_GUESSES returns 0/0/0.
- Input changes after the start cycle do not affect the result.

Decomposition:
- Package mastermind_pkg holds:
  - NUM_SLOTS, COLOR_W, MAX_GUESSES
  - COLOR_BLANK = 0, COLOR_INVALID = 7
  - Count width = 3
  - State encoding for IDLE/EXACT/PARTIAL/DONE
  - Slot-extract helper function
- One sub-module, mastermind_fb_history: MAX_GUESSES×(3+3+1) register file with one synchronous write port (Clk, Reset) and one combinational read port.

Test Plan:
- answer {1,2,3,4}, guess {1,2,3,4}, guess_num 0, start → done at cycle 21; exact 4, partial 0, win=1; rd_idx 0 gives 4/0/valid.
- answer {1,2,3,4}, guess {4,3,2,1}, guess_num 1 → exact 0, partial 4, win=0; row 1 = 0/4.
- Duplicates: answer {1,1,2,3}, guess {1,3,1,5} → exact 1, partial 2. Answer {1,1,2,2}, guess {1,2,2,2} → exact 3, partial 0.
- Blanks: answer {1,2,3,0}, guess {0,2,0,0} → exact 1, partial 0. Guess {7,7,7,7} vs answer {7,7,7,7} → 0/0, win=0.
- start re-pulsed at cycle 10 with a different guess → ignored; single done at cycle 21 with the first guess's result; busy stays 1 throughout.
- Reset asserted at cycle 12 of a score → busy=0 next cycle, no done pulse, all rd_valid=0. guess_num 6 scored → done and counts valid, no history row written.

Source files
------------

// File: rtl/mastermind_pkg.sv
// Shared constants, state encoding and slot helpers for the Mastermind guess scorer.
package mastermind_pkg;

    localparam int NUM_SLOTS   = 4;
    localparam int COLOR_W     = 3;
    localparam int MAX_GUESSES = 6;
    localparam int CNT_W       = 3;
    localparam int IDX_W       = 3;
    localparam int CODE_W      = NUM_SLOTS * COLOR_W;
    localparam int SLOT_IDX_W  = $clog2(NUM_SLOTS);
    localparam int STEP_W      = 2 * SLOT_IDX_W;

    localparam logic [COLOR_W-1:0]    COLOR_BLANK   = 3'd0;
    localparam logic [COLOR_W-1:0]    COLOR_INVALID = 3'd7;
    localparam logic [SLOT_IDX_W-1:0] SLOT_LAST     = SLOT_IDX_W'(NUM_SLOTS - 1);
    localparam logic [STEP_W-1:0]     STEP_LAST     = STEP_W'(NUM_SLOTS * NUM_SLOTS - 1);
    localparam logic [IDX_W-1:0]      GUESS_LIMIT   = IDX_W'(MAX_GUESSES);
    localparam logic [CNT_W-1:0]      WIN_COUNT     = CNT_W'(NUM_SLOTS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXACT   = 2'd1,
        ST_PARTIAL = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic logic [COLOR_W-1:0] slot_color(
        input logic [CODE_W-1:0]     code,
        input logic [SLOT_IDX_W-1:0] idx
    );
        return code[int'(idx) * COLOR_W +: COLOR_W];
    endfunction

    // Blank and invalid codes never score as a match.
    function automatic logic is_blank(input logic [COLOR_W-1:0] color);
        return (color == COLOR_BLANK) || (color == COLOR_INVALID);
    endfunction

endpackage

// File: rtl/mastermind_fb_history.sv
// Per-guess feedback register file: one synchronous write port, one combinational read port.
module mastermind_fb_history
    import mastermind_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [CNT_W-1:0] wr_exact,
    input  logic [CNT_W-1:0] wr_partial,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_exact,
    output logic [CNT_W-1:0] rd_partial,
    output logic             rd_valid
);

    logic [CNT_W-1:0]       exact_mem_r   [MAX_GUESSES];
    logic [CNT_W-1:0]       partial_mem_r [MAX_GUESSES];
    logic [MAX_GUESSES-1:0] valid_r;

    // Row storage; out-of-range write indices are dropped.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < MAX_GUESSES; k++) begin
                exact_mem_r[k]   <= '0;
                partial_mem_r[k] <= '0;
            end
            valid_r <= '0;
        end else if (wr_en && (wr_idx < GUESS_LIMIT)) begin
            exact_mem_r[wr_idx]   <= wr_exact;
            partial_mem_r[wr_idx] <= wr_partial;
            valid_r[wr_idx]       <= 1'b1;
        end
    end

    // Read mux; rows past the history depth read back as empty.
    always_comb begin
        rd_exact   = '0;
        rd_partial = '0;
        rd_valid   = 1'b0;
        if (rd_idx < GUESS_LIMIT) begin
            rd_exact   = exact_mem_r[rd_idx];
            rd_partial = partial_mem_r[rd_idx];
            rd_valid   = valid_r[rd_idx];
        end else begin
            rd_exact   = '0;
            rd_partial = '0;
            rd_valid   = 1'b0;
        end
    end

endmodule

// File: rtl/mastermind_scorer.sv
// Iterative Mastermind scorer: one slot comparison per cycle, exact pass then partial pass,
// with the result reported on a done pulse and logged into a feedback history.
module mastermind_scorer
    import mastermind_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [CODE_W-1:0] guess,
    input  logic [CODE_W-1:0] answer,
    input  logic [IDX_W-1:0]  guess_num,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  exact_cnt,
    output logic [CNT_W-1:0]  partial_cnt,
    output logic              win,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [CNT_W-1:0]  rd_exact,
    output logic [CNT_W-1:0]  rd_partial,
    output logic              rd_valid
);

    state_t                  state_r;
    logic [CODE_W-1:0]       guess_r;
    logic [CODE_W-1:0]       answer_r;
    logic [IDX_W-1:0]        guess_num_r;
    logic [NUM_SLOTS-1:0]    used_g_r;
    logic [NUM_SLOTS-1:0]    used_a_r;
    logic [CNT_W-1:0]        exact_r;
    logic [CNT_W-1:0]        partial_r;
    logic [STEP_W-1:0]       step_r;

    logic [SLOT_IDX_W-1:0]   slot_i_s;
    logic [SLOT_IDX_W-1:0]   slot_j_s;
    logic [COLOR_W-1:0]      g_col_s;
    logic [COLOR_W-1:0]      a_col_s;
    logic                    colour_match_s;
    logic                    exact_hit_s;
    logic                    partial_hit_s;
    logic                    last_step_s;
    logic [CNT_W-1:0]        partial_next_s;
    logic                    hist_we_s;

    // Slot selection and match decode for the comparison made this cycle.
    always_comb begin
        slot_j_s = step_r[SLOT_IDX_W-1:0];
        if (state_r == ST_PARTIAL) begin
            slot_i_s = step_r[STEP_W-1:SLOT_IDX_W];
        end else begin
            slot_i_s = step_r[SLOT_IDX_W-1:0];
        end
        g_col_s        = slot_color(guess_r, slot_i_s);
        a_col_s        = slot_color(answer_r, slot_j_s);
        colour_match_s = (g_col_s == a_col_s) && !is_blank(g_col_s);
        exact_hit_s    = 1'b0;
        partial_hit_s  = 1'b0;
        last_step_s    = 1'b0;
        case (state_r)
            ST_EXACT: begin
                exact_hit_s = colour_match_s;
                last_step_s = (slot_j_s == SLOT_LAST);
            end
            ST_PARTIAL: begin
                partial_hit_s = colour_match_s && !used_g_r[slot_i_s] && !used_a_r[slot_j_s];
                last_step_s   = (step_r == STEP_LAST);
            end
            default: begin
                exact_hit_s   = 1'b0;
                partial_hit_s = 1'b0;
                last_step_s   = 1'b0;
            end
        endcase
        partial_next_s = partial_r + {{(CNT_W-1){1'b0}}, partial_hit_s};
        hist_we_s      = (state_r == ST_PARTIAL) && last_step_s && (guess_num_r < GUESS_LIMIT);
    end

    // Scoring FSM; the result registers load on the final partial step so they are
    // visible during the DONE cycle alongside the done pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r     <= ST_IDLE;
            guess_r     <= '0;
            answer_r    <= '0;
            guess_num_r <= '0;
            used_g_r    <= '0;
            used_a_r    <= '0;
            exact_r     <= '0;
            partial_r   <= '0;
            step_r      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            win         <= 1'b0;
            exact_cnt   <= '0;
            partial_cnt <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        guess_r     <= guess;
                        answer_r    <= answer;
                        guess_num_r <= guess_num;
                        used_g_r    <= '0;
                        used_a_r    <= '0;
                        exact_r     <= '0;
                        partial_r   <= '0;
                        step_r      <= '0;
                        busy        <= 1'b1;
                        state_r     <= ST_EXACT;
                    end
                end
                ST_EXACT: begin
                    if (exact_hit_s) begin
                        exact_r            <= exact_r + CNT_W'(1);
                        used_g_r[slot_i_s] <= 1'b1;
                        used_a_r[slot_j_s] <= 1'b1;
                    end
                    if (last_step_s) begin
                        step_r  <= '0;
                        state_r <= ST_PARTIAL;
                    end else begin
                        step_r  <= step_r + STEP_W'(1);
                    end
                end
                ST_PARTIAL: begin
                    if (partial_hit_s) begin
                        partial_r          <= partial_next_s;
                        used_g_r[slot_i_s] <= 1'b1;
                        used_a_r[slot_j_s] <= 1'b1;
                    end
                    if (last_step_s) begin
                        exact_cnt   <= exact_r;
                        partial_cnt <= partial_next_s;
                        done        <= 1'b1;
                        if (exact_r == WIN_COUNT) begin
                            win <= 1'b1;
                        end
                        step_r  <= '0;
                        state_r <= ST_DONE;
                    end else begin
                        step_r  <= step_r + STEP_W'(1);
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    mastermind_fb_history u_history (
        .Clk        (Clk),
        .Reset      (Reset),
        .wr_en      (hist_we_s),
        .wr_idx     (guess_num_r),
        .wr_exact   (exact_r),
        .wr_partial (partial_next_s),
        .rd_idx     (rd_idx),
        .rd_exact   (rd_exact),
        .rd_partial (rd_partial),
        .rd_valid   (rd_valid)
    );

endmodule

// File: tb/tb_mastermind_scorer.sv
// Self-checking bench: directed table, multi-cycle corner sequences and random scores
// against a colour-count reference model.
module tb_mastermind_scorer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [11:0] guess;
    logic [11:0] answer;
    logic [2:0]  guess_num;
    logic [2:0]  rd_idx;
    logic        busy;
    logic        done;
    logic [2:0]  exact_cnt;
    logic [2:0]  partial_cnt;
    logic        win;
    logic [2:0]  rd_exact;
    logic [2:0]  rd_partial;
    logic        rd_valid;

    mastermind_scorer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .start       (start),
        .guess       (guess),
        .answer      (answer),
        .guess_num   (guess_num),
        .busy        (busy),
        .done        (done),
        .exact_cnt   (exact_cnt),
        .partial_cnt (partial_cnt),
        .win         (win),
        .rd_idx      (rd_idx),
        .rd_exact    (rd_exact),
        .rd_partial  (rd_partial),
        .rd_valid    (rd_valid)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [11:0] g;
        logic [11:0] a;
        logic [2:0]  num;
        int          exp_e;
        int          exp_p;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int hist_e [8];
    int hist_p [8];
    int hist_v [8];
    int win_exp = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [11:0] pack4(input int c0, input int c1, input int c2, input int c3);
        return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
    endfunction

    // Mastermind scoring by colour histograms: total common pegs minus exact hits.
    function automatic void ref_score(input logic [11:0] g, input logic [11:0] a,
                                      output int e, output int p);
        int cg [8];
        int ca [8];
        int tot;
        e = 0;
        tot = 0;
        for (int c = 0; c < 8; c++) begin
            cg[c] = 0;
            ca[c] = 0;
        end
        for (int s = 0; s < 4; s++) begin
            int gc;
            int ac;
            gc = int'(g[3*s +: 3]);
            ac = int'(a[3*s +: 3]);
            if (gc == ac && gc != 0 && gc != 7) e++;
            cg[gc]++;
            ca[ac]++;
        end
        for (int c = 1; c < 7; c++) tot += (cg[c] < ca[c]) ? cg[c] : ca[c];
        p = tot - e;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin
            hist_e[i] = 0;
            hist_p[i] = 0;
            hist_v[i] = 0;
        end
        win_exp = 0;
    endtask

    task automatic sweep_history(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_idx = 3'(i);
            #1;
            check($sformatf("%s rd_exact[%0d]", tag, i), int'(rd_exact), hist_e[i]);
            check($sformatf("%s rd_partial[%0d]", tag, i), int'(rd_partial), hist_p[i]);
            check($sformatf("%s rd_valid[%0d]", tag, i), int'(rd_valid), hist_v[i]);
        end
    endtask

    // One full score; optional start re-pulse or Reset at a given cycle after start.
    task automatic apply_score(input logic [11:0] g, input logic [11:0] a, input logic [2:0] num,
                               input int exp_e, input int exp_p,
                               input int repulse_at, input int reset_at, input string tag);
        int cyc;
        int dones;
        int done_cyc;
        int busy_ok;
        @(negedge Clk);
        guess = g;
        answer = a;
        guess_num = num;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        guess = 12'($urandom);
        answer = 12'($urandom);
        guess_num = 3'($urandom);
        cyc = 1;
        dones = 0;
        done_cyc = -1;
        busy_ok = 1;
        while (cyc <= 24) begin
            if (busy !== ((cyc <= 21) && (reset_at == 0 || cyc <= reset_at))) busy_ok = 0;
            if (done === 1'b1) begin
                dones++;
                done_cyc = cyc;
            end
            start = 1'b0;
            Reset = 1'b0;
            if (cyc == repulse_at) begin
                start = 1'b1;
                guess = 12'o1111;
                answer = 12'o1111;
            end
            if (cyc == reset_at) Reset = 1'b1;
            @(negedge Clk);
            cyc++;
        end
        start = 1'b0;
        Reset = 1'b0;
        check({tag, " busy_profile"}, busy_ok, 1);
        if (reset_at != 0) begin
            clear_model();
            check({tag, " done_count"}, dones, 0);
            check({tag, " exact_after_reset"}, int'(exact_cnt), 0);
            check({tag, " partial_after_reset"}, int'(partial_cnt), 0);
            check({tag, " win_after_reset"}, int'(win), 0);
        end else begin
            check({tag, " done_count"}, dones, 1);
            check({tag, " done_cycle"}, done_cyc, 21);
            check({tag, " exact"}, int'(exact_cnt), exp_e);
            check({tag, " partial"}, int'(partial_cnt), exp_p);
            if (exp_e == 4) win_exp = 1;
            check({tag, " win"}, int'(win), win_exp);
            if (num < 3'd6) begin
                hist_e[num] = exp_e;
                hist_p[num] = exp_p;
                hist_v[num] = 1;
            end
            rd_idx = num;
            #1;
            check({tag, " rd_exact"}, int'(rd_exact), hist_e[num]);
            check({tag, " rd_partial"}, int'(rd_partial), hist_p[num]);
            check({tag, " rd_valid"}, int'(rd_valid), hist_v[num]);
        end
    endtask

    vec_t vecs [7];

    initial begin
        logic [11:0] rg;
        logic [11:0] ra;
        int re;
        int rp;

        vecs[0] = '{pack4(1,2,3,4), pack4(1,2,3,4), 3'd0, 4, 0};
        vecs[1] = '{pack4(4,3,2,1), pack4(1,2,3,4), 3'd1, 0, 4};
        vecs[2] = '{pack4(1,3,1,5), pack4(1,1,2,3), 3'd2, 1, 2};
        vecs[3] = '{pack4(1,2,2,2), pack4(1,1,2,2), 3'd3, 3, 0};
        vecs[4] = '{pack4(0,2,0,0), pack4(1,2,3,0), 3'd4, 1, 0};
        vecs[5] = '{pack4(7,7,7,7), pack4(7,7,7,7), 3'd5, 0, 0};
        vecs[6] = '{pack4(6,5,6,5), pack4(5,6,5,6), 3'd6, 0, 4};

        Reset = 1'b1;
        start = 1'b0;
        guess = '0;
        answer = '0;
        guess_num = '0;
        rd_idx = '0;
        clear_model();
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset win", int'(win), 0);
        check("reset exact", int'(exact_cnt), 0);
        check("reset partial", int'(partial_cnt), 0);
        sweep_history("reset");

        for (int i = 0; i < 7; i++) begin
            apply_score(vecs[i].g, vecs[i].a, vecs[i].num, vecs[i].exp_e, vecs[i].exp_p,
                        0, 0, $sformatf("vec%0d", i));
        end
        sweep_history("table");

        // A second start mid-score must be ignored; the first guess's result stands.
        apply_score(pack4(1,2,3,4), pack4(1,2,6,6), 3'd0, 2, 0, 10, 0, "repulse");

        for (int n = 0; n < 120; n++) begin
            ra = 12'($urandom);
            rg = ($urandom_range(0, 3) == 0) ? ra : 12'($urandom);
            ref_score(rg, ra, re, rp);
            apply_score(rg, ra, 3'($urandom), re, rp, 0, 0, $sformatf("rand%0d", n));
        end
        sweep_history("random");

        apply_score(pack4(1,2,3,4), pack4(1,2,3,4), 3'd2, 4, 0, 0, 12, "abort");
        sweep_history("abort");

        apply_score(vecs[2].g, vecs[2].a, 3'd3, vecs[2].exp_e, vecs[2].exp_p, 0, 0, "recover");
        sweep_history("recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
